// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream input and instruction memory write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 32
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs incoming bytes little-endian into a word; flags the cycle the 4th byte lands.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             i_clear,
  input  logic                             i_valid,
  input  logic [BYTE_W-1:0]                i_byte,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] o_word,
  output logic                             o_word_ready
);

  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] r_lanes;
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] w_lanes;
  logic [1:0]                            r_idx;

  // The current byte is merged combinationally so the full word is usable on the 4th strobe.
  always_comb begin
    // NOTE: assigning the default before the conditional update keeps this combinational, no latch.
    w_lanes        = r_lanes;
    w_lanes[r_idx] = i_byte;
  end

  assign o_word       = w_lanes;
  assign o_word_ready = i_valid && (r_idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      r_lanes <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_idx   <= '0;
    end else if (i_valid) begin
      r_lanes <= w_lanes;
      r_idx   <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a checksummed byte frame into instruction RAM and holds the CPU until it verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int WORD_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  imem_loader_if.master    bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e              r_state;
  state_e              w_next;
  logic [BYTE_W-1:0]   r_count;
  logic [BYTE_W-1:0]   r_word_cnt;
  logic [BYTE_W-1:0]   r_csum;
  logic                w_session_start;
  logic                w_asm_valid;
  logic                w_word_ready;
  logic                w_last_word;
  logic [WORD_W-1:0]   w_word;

  assign w_session_start = start && (r_state inside {IDLE, DONE, ERR});
  assign w_asm_valid     = bus.byte_valid && (r_state == DATA);
  assign w_last_word     = w_word_ready && (r_word_cnt == r_count - 8'd1);

  imem_loader_word_assembler u_asm (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (w_session_start),
    .i_valid      (w_asm_valid),
    .i_byte       (bus.byte_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (start) w_next = COUNT;
      COUNT: if (bus.byte_valid) begin
        if (bus.byte_data == '0 || 32'(bus.byte_data) > DEPTH) w_next = ERR;
        else                                                   w_next = DATA;
      end
      DATA:  if (w_last_word) w_next = CHECK;
      CHECK: if (bus.byte_valid) w_next = (bus.byte_data == r_csum) ? DONE : ERR;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_word_cnt    <= '0;
      r_csum        <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      r_state    <= w_next;
      bus.mem_we <= w_word_ready;
      if (w_word_ready) bus.mem_wdata <= w_word;
      if (w_session_start) begin
        r_csum       <= '0;
        r_word_cnt   <= '0;
        bus.mem_addr <= '0;
      end else begin
        if (r_state == COUNT && bus.byte_valid) r_count <= bus.byte_data;
        if (w_asm_valid)  r_csum     <= r_csum ^ bus.byte_data;
        if (w_word_ready) r_word_cnt <= r_word_cnt + 8'd1;
        // After the final word the FSM is already in CHECK, so the address stops at N-1.
        if (bus.mem_we && r_state == DATA) bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
      end
    end
  end

  assign busy     = r_state inside {COUNT, DATA, CHECK};
  assign done     = (r_state == DONE);
  assign err      = (r_state == ERR);
  assign cpu_hold = (r_state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, count bounds, full load, reset and start abuse.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic cpu_hold, busy, done, err;

  int n_vec    = 0;
  int n_err    = 0;
  int n_writes = 0;
  int exp_writes;

  imem_loader_if #(.ADDR_W(5), .WORD_W(32)) bus ();

  imem_loader #(.ADDR_W(5), .DEPTH(32), .WORD_W(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.mem_we === 1'b1) n_writes++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [4:0] addr);
    for (int b = 0; b < 4; b++) begin
      send(w[8*b +: 8]);
      if (b == 2) check("we_early", 32'(bus.mem_we), 32'd0);
    end
    check("we", 32'(bus.mem_we), 32'd1);
    check("addr", 32'(bus.mem_addr), 32'(addr));
    check("wdata", bus.mem_wdata, w);
  endtask

  task automatic check_status(input string tag, input logic b, input logic d,
                              input logic e, input logic h);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"},  32'(err),  32'(e));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(h));
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    #1;
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_status("idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Bytes without a start are ignored.
    send(8'h02); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check_status("nostart", 1'b0, 1'b0, 1'b0, 1'b1);
    check("nostart_writes", 32'(n_writes), 32'd0);

    // Good two-word frame, checksum 13^50^93^10 = C0.
    pulse_start();
    check_status("start", 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h02);
    send_word(32'h0050_0013, 5'd0);
    send_word(32'h0010_0093, 5'd1);
    send(8'hC0);
    check_status("good", 1'b0, 1'b1, 1'b0, 1'b0);
    check("good_we_low", 32'(bus.mem_we), 32'd0);
    check("good_writes", 32'(n_writes), 32'd2);

    // Same frame, wrong checksum.
    pulse_start();
    send(8'h02);
    send_word(32'h0050_0013, 5'd0);
    send_word(32'h0010_0093, 5'd1);
    send(8'hC1);
    check_status("badsum", 1'b0, 1'b0, 1'b1, 1'b1);
    check("badsum_writes", 32'(n_writes), 32'd4);

    // Count bounds: 0 and DEPTH+1 both rejected with no writes.
    pulse_start();
    send(8'h00);
    check_status("cnt0", 1'b0, 1'b0, 1'b1, 1'b1);
    pulse_start();
    check("cnt21_clr_err", 32'(err), 32'd0);
    send(8'h21);
    check_status("cnt21", 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("cnt_writes", 32'(n_writes), 32'd4);

    // Full load, N=32, back-to-back bytes; each byte lane XORs to 00 over the frame.
    exp_writes = n_writes + 32;
    pulse_start();
    send(8'h20);
    for (int i = 0; i < 32; i++)
      send_word({8'(i), 8'h5A, 8'hC3, 8'(i)}, 5'(i));
    send(8'h00);
    check_status("full", 1'b0, 1'b1, 1'b0, 1'b0);
    check("full_writes", 32'(n_writes), 32'(exp_writes));
    check("full_addr_hold", 32'(bus.mem_addr), 32'd31);

    // Reset in the middle of a session.
    pulse_start();
    send(8'h02);
    send_word(32'h4433_2211, 5'd0);
    send(8'h55);
    send(8'h66);
    reset_n = 1'b0;
    #1;
    check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_we", 32'(bus.mem_we), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start();
    send(8'h01);
    send_word(32'h1234_5678, 5'd0);
    send(8'h08);
    check_status("postrst", 1'b0, 1'b1, 1'b0, 1'b0);

    // start during DATA is ignored; checksum EF^BE^AD^DE = 22.
    pulse_start();
    send(8'h01);
    send(8'hEF);
    send(8'hBE);
    pulse_start();
    check_status("start_busy", 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'hAD);
    send(8'hDE);
    check("sb_we", 32'(bus.mem_we), 32'd1);
    check("sb_addr", 32'(bus.mem_addr), 32'd0);
    check("sb_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    send(8'h22);
    check_status("sb_done", 1'b0, 1'b1, 1'b0, 1'b0);

    // Stray bytes in DONE change nothing.
    send(8'h01); send(8'h02);
    check_status("done_sticky", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
